mdu_issue_ctrl: RTL and testbench

//  Issue/collect stage for the RV32M multiplier/divider.
//  - Accepts one decoded M-op at a time from execute over valid/ready.
//  - Holds the operands and drives the multiplier's r1/r2/op/en/rst.
//  - Waits for the multiplier to finish and presents the result to writeback over valid/ready.
//  - Handles pipeline flush and multiplier timeout.

---
 rtl/mdu_issue_ctrl_pkg.sv | 33 +++
 rtl/mdu_special_case.sv | 62 ++++++
 rtl/mdu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared types and constants for the RV32M issue/collect stage.
// The optional special-case bypass is enabled by defining MDU_SPECIAL_EN.
package mdu_issue_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [IDX_W-1:0] reg_idx_t;

    // Encoding follows the RV32M funct3 field
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

    localparam word_t WORD_MIN  = 32'h8000_0000;
    localparam word_t WORD_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_special_case.sv
// Divide special cases resolved without the multiplier (MDU_SPECIAL_EN builds only).
`ifdef MDU_SPECIAL_EN
module mdu_special_case
    import mdu_issue_ctrl_pkg::*;
(
    input  mul_op_t     op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] value
);

    logic w_div_zero;
    logic w_overflow;

    assign w_div_zero = (rs2 == '0);
    assign w_overflow = (rs1 == WORD_MIN) && (rs2 == WORD_ONES);

    // Divide-by-zero and signed overflow results fixed by the ISA
    always_comb begin
        hit   = 1'b0;
        value = '0;
        unique case (op)
            DIV: begin
                if (w_div_zero) begin
                    hit   = 1'b1;
                    value = WORD_ONES;
                end else if (w_overflow) begin
                    hit   = 1'b1;
                    value = WORD_MIN;
                end
            end
            DIVU: begin
                if (w_div_zero) begin
                    hit   = 1'b1;
                    value = WORD_ONES;
                end
            end
            REM: begin
                if (w_div_zero) begin
                    hit   = 1'b1;
                    value = rs1;
                end else if (w_overflow) begin
                    hit   = 1'b1;
                    value = '0;
                end
            end
            REMU: begin
                if (w_div_zero) begin
                    hit   = 1'b1;
                    value = rs1;
                end
            end
            default: begin
                hit   = 1'b0;
                value = '0;
            end
        endcase
    end

endmodule
`endif

// File: rtl/mdu_issue_ctrl.sv
// Issue/collect stage for the RV32M multiplier/divider: holds one M-op,
// launches it, waits for completion or timeout, and hands the result to
// writeback. Define MDU_SPECIAL_EN to resolve divide corner cases at accept.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MIN_WAIT    = 1,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  mul_op_t     in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd_idx,
    output logic        mul_en,
    output logic        mul_rst,
    output mul_op_t     mul_op,
    output logic [31:0] mul_r1,
    output logic [31:0] mul_r2,
    input  logic [31:0] mul_rd,
    input  logic        mul_busy,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd_idx,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    mdu_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    mul_op_t    r_op;
    word_t      r_rs1, r_rs2, r_wb_data;
    reg_idx_t   r_rd_idx;
    logic       r_wb_err, r_in_ready, r_mul_en, r_mul_rst, r_wb_valid;

    logic       w_accept, w_done, w_timeout, w_abort, w_spec_take;
    logic       w_spec_hit;
    word_t      w_spec_val;

`ifdef MDU_SPECIAL_EN
    mdu_special_case u_special (
        .op    (in_op),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .hit   (w_spec_hit),
        .value (w_spec_val)
    );
`else
    assign w_spec_hit = 1'b0;
    assign w_spec_val = '0;
`endif

    // Saturating wait-cycle count including the current WAIT cycle
    assign w_cnt_inc = (r_cnt == CNT_W'(TIMEOUT_CYC)) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state and event decode; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_abort     = 1'b0;
        w_spec_take = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (w_spec_hit) begin
                        w_spec_take = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if ((w_cnt_inc >= CNT_W'(MIN_WAIT)) && !mul_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_done      = 1'b0;
            w_timeout   = 1'b0;
            w_spec_take = 1'b0;
            w_abort     = (r_state == ISSUE) || (r_state == WAIT);
        end
    end

    // State, counter and registered handshake/control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_mul_en   <= 1'b0;
            r_mul_rst  <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt == IDLE);
            r_mul_en   <= (w_state_nxt == ISSUE);
            r_mul_rst  <= w_abort || w_timeout;
            r_wb_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand hold and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= MUL;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd_idx  <= '0;
            r_wb_data <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= in_op;
                r_rs1    <= in_rs1;
                r_rs2    <= in_rs2;
                r_rd_idx <= in_rd_idx;
                r_wb_err <= 1'b0;
            end
            if (w_spec_take) begin
                r_wb_data <= w_spec_val;
            end else if (w_done) begin
                r_wb_data <= mul_rd;
                r_wb_err  <= 1'b0;
            end else if (w_timeout) begin
                r_wb_data <= '0;
                r_wb_err  <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_en    = r_mul_en;
    assign mul_rst   = r_mul_rst;
    assign mul_op    = r_op;
    assign mul_r1    = r_rs1;
    assign mul_r2    = r_rs2;
    assign wb_valid  = r_wb_valid;
    assign wb_rd_idx = r_rd_idx;
    assign wb_data   = r_wb_data;
    assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural multiplier model.
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready;
    mul_op_t     in_op;
    logic [31:0] in_rs1, in_rs2;
    logic [4:0]  in_rd_idx;
    logic        mul_en, mul_rst;
    mul_op_t     mul_op;
    logic [31:0] mul_r1, mul_r2, mul_rd;
    logic        mul_busy;
    logic        wb_valid, wb_ready, wb_err;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;

    mdu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_idx(in_rd_idx),
        .mul_en(mul_en), .mul_rst(mul_rst), .mul_op(mul_op),
        .mul_r1(mul_r1), .mul_r2(mul_r2), .mul_rd(mul_rd), .mul_busy(mul_busy),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_idx(wb_rd_idx),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier/divider: busy for 'lat' cycles after mul_en
    int          lat;
    logic        force_busy;
    logic        m_busy;
    int          m_left;
    logic [31:0] m_res, m_pend;

    function automatic logic [31:0] mdu_ref(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            MUL:  return p[31:0];
            DIV:  return (b == 0) ? 32'hFFFF_FFFF :
                         ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:  return (b == 0) ? a :
                         ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'($signed(a) % $signed(b)));
            REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_left <= 0; m_res <= '0; m_pend <= '0;
        end else if (mul_rst) begin
            m_busy <= 1'b0;
        end else if (mul_en) begin
            if (lat == 0) begin
                m_res <= mdu_ref(mul_op, mul_r1, mul_r2);
            end else begin
                m_busy <= 1'b1;
                m_left <= lat;
                m_pend <= mdu_ref(mul_op, mul_r1, mul_r2);
            end
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_res  <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    assign mul_busy = m_busy | force_busy;
    assign mul_rd   = m_res;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_en  = 0;
    int   n_rst = 0;

`ifdef MDU_SPECIAL_EN
    localparam int SPECIAL_MUL_EN = 0;
`else
    localparam int SPECIAL_MUL_EN = 2;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented result with the scoreboard head
    task automatic monitor_step();
        if (!rst_n) return;
        if (mul_en)  n_en++;
        if (mul_rst) n_rst++;
        if (wb_valid) begin
            if (q.size() == 0) begin
                check("spurious_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                check("wb_data",   wb_data,          q[0].data);
                check("wb_rd_idx", 32'(wb_rd_idx),   32'(q[0].rd));
                check("wb_err",    32'(wb_err),      32'(q[0].err));
                if (wb_ready || flush) void'(q.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input mul_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd_idx = rd;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles (counting the current one as 1) until wb_valid is seen
    task automatic wait_valid(input string nm, output int c);
        c = 1;
        while (!wb_valid && c < 200) begin
            tick();
            c++;
        end
        if (!wb_valid) check({nm, "_timeout"}, 32'(wb_valid), 32'd1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, e0, r0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = MUL;
        in_rs1 = '0; in_rs2 = '0; in_rd_idx = '0; wb_ready = 1'b0;
        lat = 2; force_busy = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mul_en",   32'(mul_en),   32'd0);
        check("rst_mul_rst",  32'(mul_rst),  32'd0);
        check("rst_mul_op",   32'(mul_op),   32'd0);
        check("rst_mul_r1",   mul_r1,        32'd0);
        check("rst_wb_data",  wb_data,       32'd0);
        check("rst_wb_err",   32'(wb_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: MUL with a never-busy multiplier gives ideal latency
        lat = 0; wb_ready = 1'b1; e0 = n_en;
        q.push_back('{rd: 5'd5, data: 32'hF7F3_F000, err: 1'b0});
        send(MUL, 32'hFFFF_FC00, 32'h0102_0304, 5'd5);
        check("t1_mul_en",  32'(mul_en), 32'd1);
        check("t1_mul_r1",  mul_r1,      32'hFFFF_FC00);
        check("t1_mul_r2",  mul_r2,      32'h0102_0304);
        wait_valid("t1", c);
        check("t1_latency", 32'(c), 32'd3);
        drain("t1");
        check("t1_en_pulses", 32'(n_en - e0), 32'd1);

        // 2: DIVU result held while writeback stalls
        lat = 3; wb_ready = 1'b0;
        q.push_back('{rd: 5'd7, data: 32'd14, err: 1'b0});
        send(DIVU, 32'd100, 32'd7, 5'd7);
        wait_valid("t2", c);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(wb_valid), 32'd1);
            check("t2_hold_ready", 32'(in_ready), 32'd0);
            check("t2_hold_r2",    mul_r2,        32'd7);
            tick();
        end
        wb_ready = 1'b1;
        check("t2_hs_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("t2_post_valid", 32'(wb_valid), 32'd0);
        check("t2_post_ready", 32'(in_ready), 32'd1);
        drain("t2");

        // 3: flush two cycles into WAIT, then a clean op
        lat = 10; r0 = n_rst;
        send(DIV, 32'd50, 32'd5, 5'd9);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_mul_rst", 32'(mul_rst),  32'd1);
        check("t3_idle",    32'(in_ready), 32'd1);
        repeat (15) tick();
        check("t3_rst_pulses", 32'(n_rst - r0), 32'd1);
        lat = 2;
        q.push_back('{rd: 5'd10, data: 32'd2, err: 1'b0});
        send(REMU, 32'd100, 32'd7, 5'd10);
        drain("t3");

        // 4: multiplier stuck busy -> timeout result
        force_busy = 1'b1; r0 = n_rst;
        q.push_back('{rd: 5'd11, data: 32'd0, err: 1'b1});
        send(MULHU, 32'd3, 32'd4, 5'd11);
        wait_valid("t4", c);
        check("t4_latency", 32'(c), 32'd66);
        check("t4_mul_rst", 32'(mul_rst), 32'd1);
        force_busy = 1'b0;
        drain("t4");
        check("t4_rst_pulses", 32'(n_rst - r0), 32'd1);

        // 5: divide corner cases
        e0 = n_en;
        q.push_back('{rd: 5'd12, data: 32'hFFFF_FFFF, err: 1'b0});
        send(DIV, 32'd5, 32'd0, 5'd12);
        drain("t5a");
        q.push_back('{rd: 5'd13, data: 32'd0, err: 1'b0});
        send(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        drain("t5b");
        check("t5_en_pulses", 32'(n_en - e0), 32'(SPECIAL_MUL_EN));

        // 6: in_valid, flush and wb_ready together in DONE
        wb_ready = 1'b0;
        q.push_back('{rd: 5'd14, data: 32'd21, err: 1'b0});
        send(MUL, 32'd3, 32'd7, 5'd14);
        wait_valid("t6", c);
        e0 = n_en;
        in_valid = 1'b1; in_op = DIVU; in_rs1 = 32'd99; in_rs2 = 32'd3; in_rd_idx = 5'd15;
        flush = 1'b1; wb_ready = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("t6_wb_valid", 32'(wb_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        repeat (10) tick();
        check("t6_no_accept", 32'(n_en - e0), 32'd0);
        check("t6_held_r1",   mul_r1,         32'd3);
        check("t6_queue",     32'(q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
